// File: rtl/count_sched_pkg.sv
// count_sched shared types: detector state encoding and symbol values.
// Imported by the interface-side modules and the shared datapath.
package count_sched_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } st_t;

    localparam logic [1:0] SYM0 = 2'd0;
    localparam logic [1:0] SYM1 = 2'd1;
    localparam logic [1:0] SYM2 = 2'd2;
    localparam logic [1:0] SYM3 = 2'd3;

endpackage

// File: rtl/count_sched_if.sv
// Requester/readout bundle for count_sched.
// master = symbol sources and status logic, slave = the scheduler.
interface count_sched_if #(
    parameter int N  = 4,
    parameter int CW = 8
);
    logic [N-1:0]    req;
    logic [2*N-1:0]  num;
    logic [N-1:0]    clr;
    logic [N-1:0]    grant;
    logic [N-1:0]    ans;
    logic [N-1:0]    hit;
    logic [N*CW-1:0] cnt;

    modport master (
        output req, num, clr,
        input  grant, ans, hit, cnt
    );

    modport slave (
        input  req, num, clr,
        output grant, ans, hit, cnt
    );
endinterface

// File: rtl/count_sched_seq_next.sv
// Shared 1-2-3 detector step: next state and completed-match flag.
// Purely combinational; one instance serves every channel.
module seq_next
    import count_sched_pkg::*;
(
    input  st_t        st,
    input  logic [1:0] sym,
    output st_t        nst,
    output logic       match
);

    always_comb begin
        nst   = S0;
        match = 1'b0;
        unique case (st)
            S0: begin
                if (sym == SYM1) nst = S1;
            end
            S1: begin
                if (sym == SYM1)      nst = S1;
                else if (sym == SYM2) nst = S2;
            end
            S2: begin
                if (sym == SYM1)      nst = S1;
                else if (sym == SYM2) nst = S2;
                else if (sym == SYM3) begin
                    nst   = S3;
                    match = 1'b1;
                end
            end
            S3: begin
                if (sym == SYM1)      nst = S1;
                else if (sym == SYM3) nst = S3;
            end
        endcase
    end

endmodule

// File: rtl/count_sched.sv
// Round-robin scheduler sharing one 1-2-3 detector among N channels,
// each with its own saved state, match pulse and saturating counter.
module count_sched
    import count_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input logic          clk,
    input logic          reset,
    count_sched_if.slave bus
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] nptr;
    logic [PW-1:0] idx;
    logic [PW-1:0] gidx;
    logic          gv;
    logic [N-1:0]  elig;
    logic [N-1:0]  gnt;

    st_t           state [N];
    logic [CW-1:0] cnt_q [N];
    logic [N-1:0]  hit_q;

    st_t           cur_st;
    logic [1:0]    cur_sym;
    st_t           nst;
    logic          match;

    // First eligible channel at or after ptr, wrapping.
    always_comb begin
        elig = bus.req & ~bus.clr;
        gnt  = '0;
        gidx = '0;
        idx  = '0;
        gv   = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!gv && elig[idx]) begin
                gv   = 1'b1;
                gidx = idx;
            end
        end
        gv = gv & ~reset;
        if (gv) gnt[gidx] = 1'b1;
    end

    assign nptr = (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;

    assign cur_st  = state[gidx];
    assign cur_sym = bus.num[2*gidx +: 2];

    seq_next u_next (
        .st    (cur_st),
        .sym   (cur_sym),
        .nst   (nst),
        .match (match)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            hit_q <= '0;
            for (int i = 0; i < N; i++) begin
                state[i] <= S0;
                cnt_q[i] <= '0;
            end
        end else begin
            hit_q <= '0;
            if (gv) ptr <= nptr;
            for (int i = 0; i < N; i++) begin
                if (bus.clr[i]) begin
                    state[i] <= S0;
                    cnt_q[i] <= '0;
                end else if (gnt[i]) begin
                    state[i] <= nst;
                    if (match) begin
                        hit_q[i] <= 1'b1;
                        if (cnt_q[i] != '1)
                            cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.grant = gnt;
    assign bus.hit   = hit_q;

    for (genvar i = 0; i < N; i++) begin : g_out
        assign bus.ans[i]           = (state[i] == S3);
        assign bus.cnt[CW*i +: CW]  = cnt_q[i];
    end

endmodule

// File: tb/tb_count_sched.sv
// Bench for count_sched: prefix-progress model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_count_sched;

    localparam int N   = 4;
    localparam int CW  = 2;
    localparam int MAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    count_sched_if #(.N(N), .CW(CW)) bus ();

    count_sched #(.N(N), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // Model: progress = length of the 1,2,3 prefix seen so far.
    int mst  [N] = '{default: 0};
    int mcnt [N] = '{default: 0};
    bit mhit [N] = '{default: 0};
    int mptr     = 0;

    function automatic int nxt(input int p, input int s);
        if (s == 1) return 1;
        if (s == 2 && (p == 1 || p == 2)) return 2;
        if (s == 3 && (p == 2 || p == 3)) return 3;
        return 0;
    endfunction

    function automatic int mgrant();
        int c;
        if (reset) return -1;
        for (int k = 0; k < N; k++) begin
            c = (mptr + k) % N;
            if (bus.req[c] && !bus.clr[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin : mdl
        int g;
        int s;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                mst[i]  <= 0;
                mcnt[i] <= 0;
                mhit[i] <= 1'b0;
            end
            mptr <= 0;
        end else begin
            g = mgrant();
            for (int i = 0; i < N; i++) begin
                s = int'(bus.num[2*i +: 2]);
                if (bus.clr[i]) begin
                    mst[i]  <= 0;
                    mcnt[i] <= 0;
                    mhit[i] <= 1'b0;
                end else if (i == g) begin
                    mst[i]  <= nxt(mst[i], s);
                    mhit[i] <= (mst[i] == 2 && s == 3);
                    if (mst[i] == 2 && s == 3 && mcnt[i] < MAX)
                        mcnt[i] <= mcnt[i] + 1;
                end else begin
                    mhit[i] <= 1'b0;
                end
            end
            if (g >= 0) mptr <= (g + 1) % N;
        end
    end

    always @(negedge clk) begin : cmp
        int g;
        logic [N-1:0] eg;
        g  = mgrant();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("grant", 32'(bus.grant), 32'(eg));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("ans%0d", i), 32'(bus.ans[i]), 32'(mst[i] == 3));
            chk($sformatf("hit%0d", i), 32'(bus.hit[i]), 32'(mhit[i]));
            chk($sformatf("cnt%0d", i), 32'(bus.cnt[CW*i +: CW]),
                32'(mcnt[i]));
        end
    end

    logic [N-1:0] g;

    task automatic cyc(input logic [N-1:0] r, input logic [2*N-1:0] n,
                       input logic [N-1:0] c, output logic [N-1:0] go);
        bus.req = r;
        bus.num = n;
        bus.clr = c;
        #1 go = bus.grant;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        bus.req = '0;
        bus.num = '0;
        bus.clr = '0;
        reset   = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    int syms1 [5] = '{1, 2, 3, 3, 0};
    int ans1  [5] = '{0, 0, 1, 1, 0};
    int hit1  [5] = '{0, 0, 1, 0, 0};
    int gseq  [5] = '{1, 2, 4, 8, 1};
    int i1, i3, hits, lim;

    initial begin
        bus.req = '0;
        bus.num = '0;
        bus.clr = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_ans", 32'(bus.ans), 0);
        chk("rst_cnt", 32'(bus.cnt), 0);
        chk("rst_hit", 32'(bus.hit), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Channel 0 alone: 1,2,3,3,0
        for (int k = 0; k < 5; k++) begin
            cyc(4'b0001, 8'(syms1[k]), 4'b0000, g);
            chk("t1_ans0", 32'(bus.ans[0]), 32'(ans1[k]));
            chk("t1_hit0", 32'(bus.hit[0]), 32'(hit1[k]));
        end
        chk("t1_cnt0", 32'(bus.cnt[CW-1:0]), 1);

        // All requesting: strict rotation from ptr 0
        rst_pulse();
        for (int k = 0; k < 5; k++) begin
            cyc(4'b1111, 8'h00, 4'b0000, g);
            chk("t2_grant", 32'(g), 32'(gseq[k]));
        end

        // Channels 1 and 3 interleave 1,2,3
        i1 = 0;
        i3 = 0;
        lim = 0;
        while ((i1 < 3 || i3 < 3) && lim < 12) begin
            cyc({1'(i3 < 3), 1'b0, 1'(i1 < 3), 1'b0},
                {2'(i3 + 1), 2'b00, 2'(i1 + 1), 2'b00}, 4'b0000, g);
            if (g[1]) i1++;
            if (g[3]) i3++;
            lim++;
        end
        chk("t3_done1", 32'(i1), 3);
        chk("t3_done3", 32'(i3), 3);
        chk("t3_cnt1", 32'(bus.cnt[CW*1 +: CW]), 1);
        chk("t3_cnt3", 32'(bus.cnt[CW*3 +: CW]), 1);
        chk("t3_ans", 32'(bus.ans), 32'b1010);

        // Clear channel 2 while it sits in S2 and requests
        cyc(4'b0100, 8'(1 << 4), 4'b0000, g);
        cyc(4'b0100, 8'(2 << 4), 4'b0000, g);
        cyc(4'b0100, 8'(3 << 4), 4'b0000, g);
        cyc(4'b0100, 8'(1 << 4), 4'b0000, g);
        cyc(4'b0100, 8'(2 << 4), 4'b0000, g);
        chk("t4_cnt2_pre", 32'(bus.cnt[CW*2 +: CW]), 1);
        cyc(4'b0110, 8'((3 << 4) | (1 << 2)), 4'b0100, g);
        chk("t4_grant_clr", 32'(g), 32'b0010);
        chk("t4_cnt2", 32'(bus.cnt[CW*2 +: CW]), 0);
        chk("t4_ans2", 32'(bus.ans[2]), 0);
        cyc(4'b0100, 8'(3 << 4), 4'b0000, g);
        chk("t4_grant2", 32'(g), 32'b0100);
        chk("t4_hit2", 32'(bus.hit[2]), 0);
        chk("t4_ans2b", 32'(bus.ans[2]), 0);

        // Saturation: five matches on a 2-bit counter
        rst_pulse();
        hits = 0;
        for (int r = 0; r < 5; r++) begin
            for (int s = 1; s <= 3; s++) begin
                cyc(4'b0001, 8'(s), 4'b0000, g);
                hits += int'(bus.hit[0]);
            end
            chk("t5_cnt0", 32'(bus.cnt[CW-1:0]), 32'((r + 1 > 3) ? 3 : r + 1));
        end
        chk("t5_hits", 32'(hits), 5);

        // Asynchronous reset mid-cycle with channel 0 in S3, cnt 2
        rst_pulse();
        for (int r = 0; r < 2; r++)
            for (int s = 1; s <= 3; s++)
                cyc(4'b0001, 8'(s), 4'b0000, g);
        chk("t6_cnt0_pre", 32'(bus.cnt[CW-1:0]), 2);
        chk("t6_ans0_pre", 32'(bus.ans[0]), 1);
        bus.req = 4'b0001;
        bus.num = 8'd1;
        #2 reset = 1'b1;
        #1;
        chk("t6_ans0", 32'(bus.ans[0]), 0);
        chk("t6_cnt0", 32'(bus.cnt[CW-1:0]), 0);
        chk("t6_grant", 32'(bus.grant), 0);
        #3 reset = 1'b0;
        bus.req = 4'b1111;
        bus.num = 8'h00;
        #1;
        chk("t6_first", 32'(bus.grant), 32'b0001);
        @(posedge clk);
        #1;
        chk("t6_second", 32'(bus.grant), 32'b0010);
        bus.req = '0;
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/count_sched.md
# count_sched

Round-robin scheduler that time-shares one 1-2-3 sequence-detector datapath among N symbol requesters. Each channel keeps its own saved detector state, match flag and saturating match counter. Each cycle at most one requester is granted, and its 2-bit symbol advances only that channel's context. The block sits between the symbol sources and the status/readout logic, and replaces N separate detector instances.

## Interface
Parameters:
- N, 4, number of requesting channels (2..8)
- CW, 8, width of each per-channel match counter

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req  in  N  req[i]=1: channel i has a valid symbol this cycle
- num  in  2N  num[2i+1:2i] = symbol of channel i, meaningful only when req[i]=1
- clr  in  N  synchronous per-channel context clear
- grant  out  N  one-hot or zero, combinational; grant[i]=1 means channel i's symbol is consumed at this edge
- ans  out  N  registered; ans[i]=1 iff channel i's saved state is S3
- hit  out  N  registered one-cycle pulse; channel i has just completed 1,2,3
- cnt  out  N*CW  cnt[CW*i+CW-1:CW*i] = completed-match count of channel i, saturating

## Operation
- Detector states S0=2'b00, S1=2'b01, S2=2'b10, S3=2'b11. One 2-bit state register per channel.
- Next-state function on symbol s:
  - S0: s=1→S1, otherwise S0.
  - S1: 1→S1, 2→S2, 0/3→S0.
  - S2: 1→S1, 2→S2, 3→S3, 0→S0.
  - S3: 1→S1, 3→S3, 0/2→S0.
- Arbitration:
  - Eligible set: req & ~clr.
  - Round-robin pointer ptr (log2 N bits) names the highest-priority channel.
  - Grant goes to the first eligible channel scanning ptr, ptr+1, …, wrapping mod N.
  - After a grant to channel g, ptr ← (g+1) mod N.
  - With no grant, ptr holds.
- Granted channel g at the edge:
  - state[g] ← next(state[g], num_g).
  - hit[g] ← 1 iff state[g]=S2 and num_g=3.
  - cnt[g] increments on that same condition, holding at 2^CW−1.
- S3→S3 on repeated 3s is not a new match: no hit, no count.
- Ungranted channels hold state and counter; their hit is 0.
- clr[i]=1 at the edge: state[i]←S0, cnt[i]←0, hit[i]←0. clr takes priority, and channel i is not granted that cycle.
- ans = (state==S3) per channel, driven directly from the state registers.

## Timing
- Reset values: every state S0, every cnt 0, hit 0, ans 0, ptr 0.
- While reset is high, grant is forced to 0.
- grant is combinational from req, clr and ptr, with zero latency. The symbol must be stable while grant is high; it is consumed at the edge.
- A requester with req held high is granted within N cycles (starvation bound).
- A requester not granted keeps req and num asserted; nothing is latched for it.
- ans, hit and cnt update one edge after the granted symbol: the symbol is accepted at edge k and its effect is visible after edge k.
- hit is a single-cycle pulse per match. Back-to-back matches on different channels give pulses in different cycles.
- Counter wrap: never. Saturation holds at the maximum value, and a hit is still pulsed at saturation.
- Reset asserted mid-stream clears everything asynchronously. The first edge after release behaves as post-reset, with ptr=0.

## Structure
- Shared package: state encodings S0..S3 and symbol constants.
- Sub-module seq_next: combinational next-state plus match flag, taking (state, sym) and returning (nstate, match). It is instantiated once, because the datapath is shared.
- Top level holds:
  - the arbiter, kept inline;
  - ptr;
  - per-channel state, cnt and hit registers;
  - a mux selecting state[g] and num_g into seq_next.

## Test plan
- Single channel 0 (N=4), symbols 1,2,3,3,0: ans0 goes 0,0,1,1,0 after the respective edges; hit0 pulses once after the third edge; cnt0=1.
- All four req high every cycle: grant sequence 0001,0010,0100,1000,0001. ptr wraps, and each channel is granted exactly once per 4 cycles.
- Channels 1 and 3 interleave 1,2,3 each under arbitration: each completes independently, cnt1=cnt3=1, and there is no cross-channel state corruption.
- Apply clr[2] while req[2]=1 with state S2: no grant to 2 that cycle, state2=S0, cnt2=0. The next eligible channel is granted instead.
- With CW=2, feed channel 0 the sequence 1,2,3 five times: cnt0 reaches 3 and holds, and hit0 pulses all 5 times.
- Assert reset asynchronously between edges while channel 0 is in S3 with cnt0=2: ans0, cnt0 and grant go to 0 immediately. After release, req=1111 grants channel 0 first.
